// File: rtl/prco_uart_loader_pkg.sv
// Shared constants for the PRCO UART boot loader: frame FSM state
// encodings plus the default sync marker and image size limit.
package prco_constants;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DAT_HI = 3'd3,
        ST_DAT_LO = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         MAX_WORDS_DEFAULT = 256;

endpackage

// File: rtl/prco_loader_rx_if.sv
// RX FIFO handshake for the boot loader. Latches the FIFO head byte,
// pops it with a one-cycle strobe and flags the same cycle as the
// byte-valid strobe for the frame FSM. No new byte is sampled while a
// pop is outstanding, which caps throughput at one byte per two cycles.
module prco_loader_rx_if (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_empty,
    output logic       q_rx_pop,
    output logic       q_byte_valid,
    output logic [7:0] q_byte
);

    logic       pop_q;
    logic       pop_d;
    logic [7:0] byte_q;
    logic [7:0] byte_d;

    // Sample the head byte only when data is present and no pop is pending
    always_comb begin
        pop_d  = 1'b0;
        byte_d = byte_q;
        if (!i_rx_empty && !pop_q) begin
            pop_d  = 1'b1;
            byte_d = i_rx_byte;
        end
    end

    // Pop strobe and latched byte registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pop_q  <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            pop_q  <= pop_d;
            byte_q <= byte_d;
        end
    end

    assign q_rx_pop     = pop_q;
    assign q_byte_valid = pop_q;
    assign q_byte       = byte_q;

endmodule

// File: rtl/prco_uart_loader.sv
// UART boot loader: parses SYNC, LEN_HI, LEN_LO, LEN big-endian words and
// an XOR checksum, writes the words to local memory from address 0 and
// releases the core from reset only after the checksum matches.
// Optional inter-byte timeout is compiled in with PRCO_LOADER_TIMEOUT_EN.
module prco_uart_loader
    import prco_constants::*;
#(
    parameter int         ADDR_W         = 16,
    parameter int         MAX_WORDS      = MAX_WORDS_DEFAULT,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_rx_empty,
    output logic              q_rx_pop,
    output logic              q_mem_we,
    output logic [ADDR_W-1:0] q_mem_addr,
    output logic [15:0]       q_mem_din,
    output logic              q_core_reset,
    output logic              q_busy,
    output logic              q_done,
    output logic              q_error
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       count_q, count_d;
    logic [7:0]        lenHi_q, lenHi_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [15:0]       din_q, din_d;
    logic              core_q, core_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              byteValid;
    logic [7:0]        rxByte;
    logic [15:0]       lenWord;

    prco_loader_rx_if u_rx_if (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_byte    (i_rx_byte),
        .i_rx_empty   (i_rx_empty),
        .q_rx_pop     (q_rx_pop),
        .q_byte_valid (byteValid),
        .q_byte       (rxByte)
    );

    assign lenWord = {lenHi_q, rxByte};

`ifdef PRCO_LOADER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             frameActive;
    logic             timeout;

    assign frameActive = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
    assign timer_d     = (!frameActive || byteValid) ? '0 : timer_q + TMR_W'(1);
    assign timeout     = frameActive && !byteValid && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter that restarts on every byte inside a frame
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    // Frame parser: next state, counters, checksum and output flags
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        lenHi_d = lenHi_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        din_d   = din_q;
        core_d  = core_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (byteValid && rxByte == SYNC_BYTE) begin
                    state_d = ST_LEN_HI;
                    addr_d  = '0;
                    csum_d  = 8'h00;
                    core_d  = 1'b1;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (byteValid) begin
                    lenHi_d = rxByte;
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (byteValid) begin
                    if (lenWord == 16'd0 || {1'b0, lenWord} > MAX_LEN) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        count_d = lenWord;
                        state_d = ST_DAT_HI;
                    end
                end
            end
            ST_DAT_HI: begin
                if (byteValid) begin
                    hi_d    = rxByte;
                    csum_d  = csum_q ^ rxByte;
                    state_d = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                if (byteValid) begin
                    we_d    = 1'b1;
                    din_d   = {hi_q, rxByte};
                    csum_d  = csum_q ^ rxByte;
                    count_d = count_q - 16'd1;
                    state_d = (count_q == 16'd1) ? ST_CSUM : ST_DAT_HI;
                end
            end
            ST_CSUM: begin
                if (byteValid) begin
                    busy_d = 1'b0;
                    if (rxByte == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        core_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PRCO_LOADER_TIMEOUT_EN
        if (timeout) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= 16'd0;
            lenHi_q <= 8'h00;
            hi_q    <= 8'h00;
            csum_q  <= 8'h00;
            we_q    <= 1'b0;
            din_q   <= 16'h0000;
            core_q  <= 1'b1;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            lenHi_q <= lenHi_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            din_q   <= din_d;
            core_q  <= core_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q_mem_we     = we_q;
    assign q_mem_addr   = addr_q;
    assign q_mem_din    = din_q;
    assign q_core_reset = core_q;
    assign q_busy       = busy_q;
    assign q_done       = done_q;
    assign q_error      = err_q;

endmodule

// File: tb/tb_prco_uart_loader.sv
// Directed testbench for prco_uart_loader: feeds byte frames through a
// modelled RX FIFO and checks memory writes and status flags.
module tb_prco_uart_loader;

    logic        i_clk;
    logic        i_reset;
    logic [7:0]  i_rx_byte;
    logic        i_rx_empty;
    logic        q_rx_pop;
    logic        q_mem_we;
    logic [15:0] q_mem_addr;
    logic [15:0] q_mem_din;
    logic        q_core_reset;
    logic        q_busy;
    logic        q_done;
    logic        q_error;

    int checks;
    int errors;

    logic [7:0]  txBuf [0:599];
    int          txLen;

    int          wrCount;
    int          doneCount;
    logic [15:0] wrAddr [0:511];
    logic [15:0] wrData [0:511];

    prco_uart_loader #(
        .ADDR_W    (16),
        .MAX_WORDS (256),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_byte    (i_rx_byte),
        .i_rx_empty   (i_rx_empty),
        .q_rx_pop     (q_rx_pop),
        .q_mem_we     (q_mem_we),
        .q_mem_addr   (q_mem_addr),
        .q_mem_din    (q_mem_din),
        .q_core_reset (q_core_reset),
        .q_busy       (q_busy),
        .q_done       (q_done),
        .q_error      (q_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Record every memory write and done pulse away from the active edge
    always @(negedge i_clk) begin
        if (q_mem_we) begin
            wrAddr[wrCount % 512] = q_mem_addr;
            wrData[wrCount % 512] = q_mem_din;
            wrCount = wrCount + 1;
        end
        if (q_done) doneCount = doneCount + 1;
    end

    // Present txBuf through the FIFO model, advancing on each pop
    task automatic applyStimulus();
        bit found;
        @(negedge i_clk);
        for (int i = 0; i < txLen; i++) begin
            i_rx_byte  = txBuf[i];
            i_rx_empty = 1'b0;
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge i_clk);
                if (q_rx_pop) found = 1'b1;
            end
            if (!found) begin
                checks++;
                errors++;
                $display("[TB] FAIL pop_wait byte %0d: no pop seen, required pop within 8 cycles", i);
            end
        end
        i_rx_empty = 1'b1;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic doReset();
        @(negedge i_clk);
        i_reset    = 1'b1;
        i_rx_empty = 1'b1;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic loadGoodFrame();
        txBuf[0] = 8'hA5; txBuf[1] = 8'h00; txBuf[2] = 8'h02;
        txBuf[3] = 8'h12; txBuf[4] = 8'h34; txBuf[5] = 8'hAB;
        txBuf[6] = 8'hCD; txBuf[7] = 8'h40;
        txLen = 8;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({q_core_reset, q_busy, q_done, q_error, q_mem_we, q_rx_pop} !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b, required 100000", {q_core_reset, q_busy, q_done, q_error, q_mem_we, q_rx_pop});
        end
        checks++;
        if (q_mem_addr !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_addr: got %h, required 0000", q_mem_addr);
        end
    endtask

    task automatic test_good_frame();
        int w0 = wrCount;
        int d0 = doneCount;
        loadGoodFrame();
        applyStimulus();
        checks++;
        if (wrCount - w0 !== 2) begin
            errors++;
            $display("[TB] FAIL good_writes: got %0d, required 2", wrCount - w0);
        end
        checks++;
        if (wrAddr[w0 % 512] !== 16'd0 || wrData[w0 % 512] !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL good_word0: got %h@%h, required 1234@0000", wrData[w0 % 512], wrAddr[w0 % 512]);
        end
        checks++;
        if (wrAddr[(w0 + 1) % 512] !== 16'd1 || wrData[(w0 + 1) % 512] !== 16'hABCD) begin
            errors++;
            $display("[TB] FAIL good_word1: got %h@%h, required ABCD@0001", wrData[(w0 + 1) % 512], wrAddr[(w0 + 1) % 512]);
        end
        checks++;
        if (doneCount - d0 !== 1) begin
            errors++;
            $display("[TB] FAIL good_done: got %0d pulses, required 1", doneCount - d0);
        end
        checks++;
        if ({q_core_reset, q_error, q_busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL good_flags: core/err/busy got %b, required 000", {q_core_reset, q_error, q_busy});
        end
    endtask

    task automatic test_bad_csum();
        int w0 = wrCount;
        int d0 = doneCount;
        loadGoodFrame();
        txBuf[7] = 8'h41;
        applyStimulus();
        checks++;
        if (wrCount - w0 !== 2) begin
            errors++;
            $display("[TB] FAIL badcsum_writes: got %0d, required 2", wrCount - w0);
        end
        checks++;
        if ({q_core_reset, q_error, q_busy} !== 3'b110 || doneCount != d0) begin
            errors++;
            $display("[TB] FAIL badcsum_flags: core/err/busy got %b done %0d, required 110 done 0", {q_core_reset, q_error, q_busy}, doneCount - d0);
        end
        loadGoodFrame();
        applyStimulus();
        checks++;
        if ({q_core_reset, q_error} !== 2'b00 || doneCount - d0 !== 1) begin
            errors++;
            $display("[TB] FAIL badcsum_recover: core/err got %b done %0d, required 00 done 1", {q_core_reset, q_error}, doneCount - d0);
        end
    endtask

    task automatic test_bad_len();
        int w0 = wrCount;
        txBuf[0] = 8'hA5; txBuf[1] = 8'h00; txBuf[2] = 8'h00;
        txLen = 3;
        applyStimulus();
        checks++;
        if ({q_core_reset, q_error, q_busy} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL len0_flags: core/err/busy got %b, required 110", {q_core_reset, q_error, q_busy});
        end
        txBuf[0] = 8'hA5; txBuf[1] = 8'h01; txBuf[2] = 8'h01;
        txLen = 3;
        applyStimulus();
        checks++;
        if (q_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL len257_error: got %b, required 1", q_error);
        end
        checks++;
        if (wrCount - w0 !== 0) begin
            errors++;
            $display("[TB] FAIL badlen_writes: got %0d, required 0", wrCount - w0);
        end
    endtask

    task automatic test_garbage();
        int w0 = wrCount;
        int d0 = doneCount;
        txBuf[0] = 8'h00; txBuf[1] = 8'hFF; txBuf[2] = 8'h13;
        txBuf[3] = 8'hA5; txBuf[4] = 8'h00; txBuf[5] = 8'h01;
        txBuf[6] = 8'hBE; txBuf[7] = 8'hEF; txBuf[8] = 8'h51;
        txLen = 9;
        applyStimulus();
        checks++;
        if (wrCount - w0 !== 1 || wrAddr[w0 % 512] !== 16'd0 || wrData[w0 % 512] !== 16'hBEEF) begin
            errors++;
            $display("[TB] FAIL garbage_write: count %0d got %h@%h, required 1 write BEEF@0000", wrCount - w0, wrData[w0 % 512], wrAddr[w0 % 512]);
        end
        checks++;
        if (doneCount - d0 !== 1 || {q_core_reset, q_error} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL garbage_done: done %0d core/err %b, required 1 and 00", doneCount - d0, {q_core_reset, q_error});
        end
    endtask

    task automatic test_reset_midframe();
        int w0;
        int d0;
        txBuf[0] = 8'hA5; txBuf[1] = 8'h00; txBuf[2] = 8'h02;
        txBuf[3] = 8'h12; txBuf[4] = 8'h34;
        txLen = 5;
        applyStimulus();
        checks++;
        if (q_busy !== 1'b1 || q_mem_addr !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midframe_busy: busy %b addr %h, required 1 and 0001", q_busy, q_mem_addr);
        end
        doReset();
        checks++;
        if ({q_core_reset, q_busy, q_done, q_error, q_mem_we} !== 5'b10000 || q_mem_addr !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midframe_reset: flags %b addr %h, required 10000 and 0000", {q_core_reset, q_busy, q_done, q_error, q_mem_we}, q_mem_addr);
        end
        w0 = wrCount;
        d0 = doneCount;
        txBuf[0] = 8'hA5; txBuf[1] = 8'h00; txBuf[2] = 8'h01;
        txBuf[3] = 8'hA5; txBuf[4] = 8'h5A; txBuf[5] = 8'hFF;
        txLen = 6;
        applyStimulus();
        checks++;
        if (wrCount - w0 !== 1 || wrAddr[w0 % 512] !== 16'd0 || wrData[w0 % 512] !== 16'hA55A || doneCount - d0 !== 1) begin
            errors++;
            $display("[TB] FAIL after_reset_frame: count %0d got %h@%h done %0d, required 1 write A55A@0000 done 1", wrCount - w0, wrData[w0 % 512], wrAddr[w0 % 512], doneCount - d0);
        end
    endtask

    task automatic test_max_len();
        int w0 = wrCount;
        int d0 = doneCount;
        txBuf[0] = 8'hA5; txBuf[1] = 8'h01; txBuf[2] = 8'h00;
        for (int k = 0; k < 256; k++) begin
            txBuf[3 + 2 * k] = 8'(k);
            txBuf[4 + 2 * k] = ~8'(k);
        end
        txBuf[515] = 8'h00;
        txLen = 516;
        applyStimulus();
        checks++;
        if (wrCount - w0 !== 256) begin
            errors++;
            $display("[TB] FAIL maxlen_writes: got %0d, required 256", wrCount - w0);
        end
        checks++;
        if (wrAddr[(w0 + 255) % 512] !== 16'd255 || wrData[(w0 + 255) % 512] !== 16'hFF00) begin
            errors++;
            $display("[TB] FAIL maxlen_last: got %h@%h, required FF00@00FF", wrData[(w0 + 255) % 512], wrAddr[(w0 + 255) % 512]);
        end
        checks++;
        if (doneCount - d0 !== 1 || {q_core_reset, q_error} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL maxlen_done: done %0d core/err %b, required 1 and 00", doneCount - d0, {q_core_reset, q_error});
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        wrCount    = 0;
        doneCount  = 0;
        txLen      = 0;
        i_reset    = 1'b1;
        i_rx_empty = 1'b1;
        i_rx_byte  = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_garbage();
        test_reset_midframe();
        test_max_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
